// File: rtl/mac_seq_if.sv
// Bundle of command, operand-stream, MAC-pin and result signals around one mac_seq instance.
// The slave modport is the sequencer's view; master is the surrounding environment's view.
interface mac_seq_if #(
   parameter int unsigned IN_WIDTH  = 8,
   parameter int unsigned OUT_WIDTH = 22,
   parameter int unsigned LEN_WIDTH = 10
);
   logic                 start;
   logic [LEN_WIDTH-1:0] length;
   logic                 abort;
   logic                 busy;
   logic                 op_valid;
   logic                 op_ready;
   logic [IN_WIDTH-1:0]  pix_in;
   logic [IN_WIDTH-1:0]  wgt_in;
   logic                 rst_mem;
   logic                 mul_mem_en;
   logic                 ac_mem_en;
   logic [IN_WIDTH-1:0]  img_in;
   logic [IN_WIDTH-1:0]  weight_in;
   logic [OUT_WIDTH-1:0] mac_out;
   logic                 res_valid;
   logic                 res_ready;
   logic [OUT_WIDTH-1:0] res_data;

   modport slave (
      input  start, length, abort, op_valid, pix_in, wgt_in, mac_out, res_ready,
      output busy, op_ready, rst_mem, mul_mem_en, ac_mem_en, img_in, weight_in,
             res_valid, res_data
   );

   modport master (
      output start, length, abort, op_valid, pix_in, wgt_in, mac_out, res_ready,
      input  busy, op_ready, rst_mem, mul_mem_en, ac_mem_en, img_in, weight_in,
             res_valid, res_data
   );
endinterface

// File: rtl/mac_seq.sv
// Job sequencer for one MAC: clears it, streams operand pairs onto its enables,
// then captures the accumulated dot product onto a valid/ready result port.
module mac_seq #(
   parameter int unsigned IN_WIDTH  = 8,
   parameter int unsigned OUT_WIDTH = 22,
   parameter int unsigned LEN_WIDTH = 10
) (
   input  logic     clk,
   input  logic     rst,
   mac_seq_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_RESULT
   } state_t;

   state_t               state_q, state_d;
   logic [LEN_WIDTH-1:0] count_q, count_d;
   logic                 acc_pend_q, acc_pend_d;
   logic                 busy_q, busy_d;
   logic                 op_ready_q, op_ready_d;
   logic                 rst_mem_q, rst_mem_d;
   logic                 res_valid_q, res_valid_d;
   logic [OUT_WIDTH-1:0] res_data_q, res_data_d;
   logic                 accept;

   // Product register loads in the same cycle the pair is handed over.
   assign accept = bus.op_valid & op_ready_q;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      acc_pend_d  = accept;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               count_d = bus.length;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            acc_pend_d = 1'b0;
            state_d    = (count_q == '0) ? S_RESULT : S_RUN;
         end
         S_RUN: begin
            if (accept) begin
               count_d = count_q - LEN_WIDTH'(1);
               if (count_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            state_d = S_RESULT;
         end
         S_RESULT: begin
            // First RESULT cycle: accumulator has settled, capture it.
            if (!res_valid_q) begin
               res_data_d  = bus.mac_out;
               res_valid_d = 1'b1;
            end else if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over every transition and discards any in-flight product.
      if (bus.abort && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         count_d     = '0;
         acc_pend_d  = 1'b0;
         res_valid_d = 1'b0;
      end

      busy_d     = (state_d != S_IDLE);
      op_ready_d = (state_d == S_RUN);
      rst_mem_d  = (state_d == S_CLEAR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         acc_pend_q  <= 1'b0;
         busy_q      <= 1'b0;
         op_ready_q  <= 1'b0;
         rst_mem_q   <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         acc_pend_q  <= acc_pend_d;
         busy_q      <= busy_d;
         op_ready_q  <= op_ready_d;
         rst_mem_q   <= rst_mem_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.op_ready   = op_ready_q;
   assign bus.rst_mem    = rst_mem_q;
   assign bus.mul_mem_en = accept;
   assign bus.ac_mem_en  = acc_pend_q;
   assign bus.img_in     = IN_WIDTH'(bus.pix_in);
   assign bus.weight_in  = IN_WIDTH'(bus.wgt_in);
   assign bus.res_valid  = res_valid_q;
   assign bus.res_data   = res_data_q;

endmodule
